// File: rtl/tdm_demux_pkg.sv
// Shared constants and state type for the 1-to-4 TDM demultiplexer.
// Imported by tdm_slot_counter and tdm_demux_1x4.
package tdm_demux_pkg;

    localparam int NUM_SLOTS  = 4;
    localparam int SLOT_IDX_W = 2;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter for the TDM demux: clear, load-to-1 and increment.
// last is high while the counter points at the final slot of a frame.
module tdm_slot_counter
    import tdm_demux_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  load1,
    input  logic                  inc,
    output logic [SLOT_IDX_W-1:0] cnt,
    output logic                  last
);

    logic [SLOT_IDX_W-1:0] cnt_q;
    logic [SLOT_IDX_W-1:0] cnt_d;

    // Next count: clear wins over load, load wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load1) begin
            cnt_d = SLOT_IDX_W'(1);
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == SLOT_IDX_W'(NUM_SLOTS - 1));

endmodule

// File: rtl/tdm_demux_1x4.sv
// 1-to-4 TDM demux: rebuilds 4-slot frames from SOF-tagged beats.
// Optional TDM_DEMUX_SYNC_ERR_EN adds a saturating sync error counter.
module tdm_demux_1x4
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_sof,
    input  logic [WIDTH-1:0]           in_data,
    output logic [NUM_SLOTS*WIDTH-1:0] out_data,
    output logic                       out_valid,
    output logic                       in_sync
`ifdef TDM_DEMUX_SYNC_ERR_EN
    ,
    output logic [7:0]                 err_cnt
`endif
);

    localparam int FW = NUM_SLOTS * WIDTH;

    state_t          state_q, state_d;
    logic [FW-1:0]   shadow_q, shadow_d;
    logic [FW-1:0]   out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            in_sync_q, in_sync_d;

    logic                  cnt_clr;
    logic                  cnt_load1;
    logic                  cnt_inc;
    logic [SLOT_IDX_W-1:0] cnt;
    logic                  cnt_last;

    tdm_slot_counter u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .load1 (cnt_load1),
        .inc   (cnt_inc),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    // Frame alignment FSM, slot capture and frame hand-off.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        cnt_clr     = 1'b0;
        cnt_load1   = 1'b0;
        cnt_inc     = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (in_sof) begin
                        shadow_d[0 +: WIDTH] = in_data;
                        cnt_load1            = 1'b1;
                        state_d              = RUN;
                    end
                end
                RUN: begin
                    if (in_sof) begin
                        // Normal or early SOF: restart at slot 0.
                        shadow_d[0 +: WIDTH] = in_data;
                        cnt_load1            = 1'b1;
                    end else if (cnt == '0) begin
                        // Expected SOF missing: lost alignment.
                        cnt_clr = 1'b1;
                        state_d = HUNT;
                    end else begin
                        for (int k = 1; k < NUM_SLOTS; k++) begin
                            if (int'(cnt) == k) begin
                                shadow_d[k*WIDTH +: WIDTH] = in_data;
                            end
                        end
                        cnt_inc = 1'b1;
                        if (cnt_last) begin
                            out_data_d  = shadow_d;
                            out_valid_d = 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        in_sync_d = (state_d == RUN);
    end

    // State, shadow and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            shadow_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_sync_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_sync_q   <= in_sync_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign in_sync   = in_sync_q;

`ifdef TDM_DEMUX_SYNC_ERR_EN
    logic       sync_err;
    logic [7:0] err_cnt_q, err_cnt_d;

    // Early SOF mid-frame or missing SOF at slot 0.
    always_comb begin
        sync_err  = 1'b0;
        if (in_valid && state_q == RUN) begin
            sync_err = in_sof ? (cnt != '0) : (cnt == '0);
        end
        err_cnt_d = err_cnt_q;
        if (sync_err && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Saturating error count, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Directed self-checking bench for tdm_demux_1x4 with WIDTH=1.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_tdm_demux_1x4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_sof;
    logic [0:0] in_data;
    logic [3:0] out_data;
    logic       out_valid;
    logic       in_sync;
`ifdef TDM_DEMUX_SYNC_ERR_EN
    logic [7:0] err_cnt;
`endif

    int total;
    int bad;
    int vcount;

    tdm_demux_1x4 #(.WIDTH(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .in_sync   (in_sync)
`ifdef TDM_DEMUX_SYNC_ERR_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid) vcount++;
    end

    task automatic drive(input logic v, input logic s, input logic d);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(3);
        @(negedge clk);
        rst = 1'b0;
        idle(5);
        total++;
        if (out_data !== 4'b0000) begin
            bad++;
            $display("FAIL reset_data got=%b exp=0000", out_data);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got=%b exp=0", out_valid);
        end
        total++;
        if (in_sync !== 1'b0) begin
            bad++;
            $display("FAIL reset_sync got=%b exp=0", in_sync);
        end
        total++;
        if (vcount != 0) begin
            bad++;
            $display("FAIL reset_pulses got=%0d exp=0", vcount);
        end
    endtask

    task automatic test_frame;
        int base;
        base = vcount;
        drive(1, 1, 1);
        total++;
        if (in_sync !== 1'b1) begin
            bad++;
            $display("FAIL frame_sync got=%b exp=1", in_sync);
        end
        drive(1, 0, 0);
        drive(1, 0, 1);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL frame_early_valid got=%b exp=0", out_valid);
        end
        drive(1, 0, 1);
        total++;
        if (out_data !== 4'b1101 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL frame_out got=%b/%b exp=1101/1", out_data, out_valid);
        end
        idle(1);
        total++;
        if (out_valid !== 1'b0 || out_data !== 4'b1101) begin
            bad++;
            $display("FAIL frame_pulse got=%b/%b exp=1101/0", out_data, out_valid);
        end
        total++;
        if (vcount - base != 1) begin
            bad++;
            $display("FAIL frame_pulses got=%0d exp=1", vcount - base);
        end
    endtask

    task automatic test_gap;
        int base;
        base = vcount;
        drive(1, 1, 0);
        drive(1, 0, 1);
        idle(3);
        total++;
        if (in_sync !== 1'b1 || out_data !== 4'b1101) begin
            bad++;
            $display("FAIL gap_hold got=%b/%b exp=1/1101", in_sync, out_data);
        end
        drive(1, 0, 1);
        drive(1, 0, 0);
        total++;
        if (out_data !== 4'b0110 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL gap_frame1 got=%b/%b exp=0110/1", out_data, out_valid);
        end
        drive(1, 1, 1);
        drive(1, 0, 1);
        drive(1, 0, 0);
        drive(1, 0, 0);
        total++;
        if (out_data !== 4'b0011 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL gap_frame2 got=%b/%b exp=0011/1", out_data, out_valid);
        end
        idle(2);
        total++;
        if (vcount - base != 2) begin
            bad++;
            $display("FAIL gap_pulses got=%0d exp=2", vcount - base);
        end
    endtask

    task automatic test_early_sof;
        int base;
        base = vcount;
        drive(1, 1, 1);
        drive(1, 0, 1);
        drive(1, 1, 0);
        total++;
        if (out_valid !== 1'b0 || out_data !== 4'b0011) begin
            bad++;
            $display("FAIL esof_discard got=%b/%b exp=0011/0", out_data, out_valid);
        end
        drive(1, 0, 1);
        drive(1, 0, 0);
        drive(1, 0, 1);
        total++;
        if (out_data !== 4'b1010 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL esof_frame got=%b/%b exp=1010/1", out_data, out_valid);
        end
        idle(1);
        total++;
        if (vcount - base != 1) begin
            bad++;
            $display("FAIL esof_pulses got=%0d exp=1", vcount - base);
        end
`ifdef TDM_DEMUX_SYNC_ERR_EN
        total++;
        if (err_cnt !== 8'd1) begin
            bad++;
            $display("FAIL esof_err got=%0d exp=1", err_cnt);
        end
`endif
    endtask

    task automatic test_hunt_drop;
        int base;
        base = vcount;
        drive(1, 0, 1);
        total++;
        if (in_sync !== 1'b0) begin
            bad++;
            $display("FAIL miss_sof_sync got=%b exp=0", in_sync);
        end
        drive(1, 0, 1);
        drive(1, 0, 0);
        drive(0, 1, 1);
        total++;
        if (in_sync !== 1'b0 || out_data !== 4'b1010) begin
            bad++;
            $display("FAIL hunt_drop got=%b/%b exp=0/1010", in_sync, out_data);
        end
        drive(1, 1, 0);
        drive(1, 0, 0);
        drive(1, 0, 1);
        drive(1, 0, 0);
        total++;
        if (out_data !== 4'b0100 || out_valid !== 1'b1 || in_sync !== 1'b1) begin
            bad++;
            $display("FAIL resync got=%b/%b/%b exp=0100/1/1",
                     out_data, out_valid, in_sync);
        end
        idle(1);
        total++;
        if (vcount - base != 1) begin
            bad++;
            $display("FAIL hunt_pulses got=%0d exp=1", vcount - base);
        end
`ifdef TDM_DEMUX_SYNC_ERR_EN
        total++;
        if (err_cnt !== 8'd2) begin
            bad++;
            $display("FAIL hunt_err got=%0d exp=2", err_cnt);
        end
`endif
    endtask

    task automatic test_reset_midframe;
        int base;
        drive(1, 1, 1);
        drive(1, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_data !== 4'b0000 || out_valid !== 1'b0 || in_sync !== 1'b0) begin
            bad++;
            $display("FAIL async_rst got=%b/%b/%b exp=0000/0/0",
                     out_data, out_valid, in_sync);
        end
        idle(2);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        base = vcount;
        total++;
        if (out_valid !== 1'b0 || in_sync !== 1'b0) begin
            bad++;
            $display("FAIL post_rst got=%b/%b exp=0/0", out_valid, in_sync);
        end
        drive(1, 1, 1);
        drive(1, 0, 1);
        drive(1, 0, 1);
        drive(1, 0, 1);
        total++;
        if (out_data !== 4'b1111 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_frame got=%b/%b exp=1111/1", out_data, out_valid);
        end
        idle(1);
        total++;
        if (vcount - base != 1) begin
            bad++;
            $display("FAIL rst_pulses got=%0d exp=1", vcount - base);
        end
`ifdef TDM_DEMUX_SYNC_ERR_EN
        total++;
        if (err_cnt !== 8'd0) begin
            bad++;
            $display("FAIL rst_err got=%0d exp=0", err_cnt);
        end
`endif
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        vcount   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 1'b0;
        test_reset();
        test_frame();
        test_gap();
        test_early_sof();
        test_hunt_drop();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1x4.md
Name: tdm_demux_1x4

Overview:
- Sequential 1-to-4 demultiplexer: the receive end of the 4-slot time-division link that the 4:1 mux drives with a rotating 2-bit select.
- Accepts one WIDTH-bit slot per valid beat, tagged with a start-of-frame marker on slot 0.
- Rebuilds the 4-slot frame and presents all four channels in parallel with a one-cycle valid pulse.
- Sits directly after the serial TDM path, feeding per-channel consumers.

Parameters:
- WIDTH, 1, bits per slot (per channel).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  the slot beat on in_data is valid this cycle.
- in_sof  input  1  start of frame; meaningful only when in_valid=1; marks slot 0.
- in_data  input  WIDTH  slot payload.
- out_data  output  4*WIDTH  reconstructed frame; channel k is in bits [k*WIDTH +: WIDTH].
- out_valid  output  1  one-cycle pulse when out_data has been updated with a complete frame.
- in_sync  output  1  high while in RUN (aligned to the frame).

Behaviour:
- Reset (async assert, released synchronously by clk): state=HUNT, slot counter=0, shadow register=0, out_data=0, out_valid=0, in_sync=0.
- States: HUNT and RUN. Slot counter is 2 bits. A shadow register holds 4*WIDTH bits.
- HUNT:
  - in_valid=1, in_sof=0: beat dropped.
  - in_valid=1, in_sof=1: in_data goes to shadow slot 0, counter becomes 1, state goes to RUN.
- RUN, beat with in_valid=1 and in_sof=0:
  - At counter 1..3: in_data goes to shadow slot[counter], counter increments.
  - At counter 3: that capture completes the frame. On the same edge, out_data is loaded with the full frame (slot 3 taken directly from in_data). Counter wraps to 0.
- RUN, in_valid=1, in_sof=1 with counter 1..3 (early SOF): partial frame is discarded, with no out_valid. The beat is captured as slot 0 and counter becomes 1.
- RUN, in_valid=1, in_sof=1 with counter 0: normal frame start. Captured as slot 0, counter becomes 1.
- RUN, counter 0, in_valid=1, in_sof=0 (missing SOF): beat dropped, state goes to HUNT.
- RUN, in_valid=0: hold all state; there is no timeout and gaps between beats are legal.
- out_valid is registered and high for exactly the cycle after the edge that captured slot 3. out_data changes only on that edge and holds otherwise.
- Latency: out_data and out_valid are visible the cycle after the 4th beat is accepted.
- in_sync = (state==RUN), registered.
- Reset mid-frame: all state clears immediately; the partial frame is lost and no out_valid is produced.
- in_sof is ignored whenever in_valid=0.

Optional Feature:
- Macro: TDM_DEMUX_SYNC_ERR_EN.
- When defined, the block adds output port err_cnt (8 bits): a saturating counter that increments on each early-SOF discard and each missing-SOF drop into HUNT.
  - Cleared only by rst.
  - Holds at 255.
- When not defined, the port and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Package tdm_demux_pkg holds:
  - NUM_SLOTS=4
  - SLOT_IDX_W=2
  - state enum {HUNT, RUN}
- One sub-module, tdm_slot_counter: 2-bit counter with clear, load-to-1 and increment controls, plus a last-slot flag. It is used by the top-level FSM.

Test Plan:
- After rst, in_valid=0 for 5 cycles -> out_data=0, out_valid=0, in_sync=0.
- Frame with WIDTH=1, beats 1(sof),0,1,1 back-to-back -> one cycle after the 4th beat, out_data=4'b1101 and out_valid is a single-cycle pulse; in_sync=1 from the cycle after the first beat.
- Two frames with 3 idle cycles between beats 2 and 3 of the first frame -> both frames are output correctly; out_valid occurs exactly twice.
- Beats with sof at slot 2 (early SOF) -> no out_valid for the partial frame; the next 4 beats form a valid frame. With TDM_DEMUX_SYNC_ERR_EN, err_cnt=1.
- Beats without sof in HUNT -> dropped, no output. A beat without sof after a completed frame -> in_sync falls to 0 and the block resumes on the next sof.
- Assert rst after 2 beats of a frame -> outputs and in_sync clear immediately and asynchronously. After release, a full frame 1,1,1,1 gives out_data=4'b1111.
